// File: rtl/operand_stack_if.sv
// Operand-stack command/status bundle: the master drives A and Sel; the slave
// (the stack) returns TOS/NOS and the occupancy and error flags.
interface operand_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] A;
  logic [SEL_W-1:0] Sel;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] Next;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             error;

  modport master (
    output A, Sel,
    input  Out, Next, count, full, empty, error
  );

  modport slave (
    input  A, Sel,
    output Out, Next, count, full, empty, error
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand store for the calculator datapath: push/pop/swap/clear decode,
// sticky error flag. Optional DUP opcode is enabled by OPERAND_STACK_DUP_EN.
module operand_stack #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter int               SEL_W      = 3,
  parameter logic [SEL_W-1:0] PUSH_CODE  = 3'b001,
  parameter logic [SEL_W-1:0] POP_CODE   = 3'b010,
  parameter logic [SEL_W-1:0] SWAP_CODE  = 3'b011,
  parameter logic [SEL_W-1:0] CLEAR_CODE = 3'b100,
  parameter logic [SEL_W-1:0] DUP_CODE   = 3'b101
) (
  input logic           clock,
  input logic           reset,
  operand_stack_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  // Index 0 is TOS. Slots at index >= cnt are kept at zero at all times.
  logic [WIDTH-1:0] stk     [DEPTH];
  logic [WIDTH-1:0] stk_nxt [DEPTH];
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             is_full, is_empty;

  assign is_full  = (cnt == CNT_FULL);
  assign is_empty = (cnt == '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) stk_nxt[i] = stk[i];
    cnt_nxt = cnt;
    err_nxt = err;

    if (bus.Sel == PUSH_CODE) begin
      if (is_full) begin
        err_nxt = 1'b1;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) stk_nxt[i] = stk[i-1];
        stk_nxt[0] = bus.A;
        cnt_nxt    = cnt + CNT_ONE;
      end
    end else if (bus.Sel == POP_CODE) begin
      if (is_empty) begin
        err_nxt = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) stk_nxt[i] = stk[i+1];
        stk_nxt[DEPTH-1] = '0;
        cnt_nxt          = cnt - CNT_ONE;
      end
    end else if (bus.Sel == SWAP_CODE) begin
      if (cnt < CNT_TWO) begin
        err_nxt = 1'b1;
      end else begin
        stk_nxt[0] = stk[1];
        stk_nxt[1] = stk[0];
      end
    end else if (bus.Sel == CLEAR_CODE) begin
      for (int i = 0; i < DEPTH; i++) stk_nxt[i] = '0;
      cnt_nxt = '0;
      err_nxt = 1'b0;
    end else if (bus.Sel == DUP_CODE) begin
`ifdef OPERAND_STACK_DUP_EN
      if (is_full || is_empty) begin
        err_nxt = 1'b1;
      end else begin
        for (int i = DEPTH - 1; i > 0; i--) stk_nxt[i] = stk[i-1];
        stk_nxt[0] = stk[0];
        cnt_nxt    = cnt + CNT_ONE;
      end
`else
      // Unassigned opcode in this build: hold, same as any other value.
      err_nxt = err;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= stk_nxt[i];
      cnt <= cnt_nxt;
      err <= err_nxt;
    end
  end

  // Masking by cnt is redundant with the zeroed-slot invariant but keeps the
  // outputs clean even if that invariant were ever broken.
  assign bus.Out   = is_empty     ? '0 : stk[0];
  assign bus.Next  = cnt < CNT_TWO ? '0 : stk[1];
  assign bus.count = cnt;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.error = err;
endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Parameterised operand store for the calculator datapath. It replaces the single-register operand holder with a LIFO of DEPTH entries, each WIDTH bits wide. The block decodes a Sel opcode each clock into one of: push, pop, swap, clear or hold. The top two entries feed the ALU directly. Status flags report occupancy, plus a sticky error for illegal operations.

Parameters:
WIDTH, 8, bits per operand entry
DEPTH, 4, number of stack entries (legal range 2..16)
SEL_W, 3, width of Sel opcode bus
PUSH_CODE, 3'b001, Sel value that pushes A
POP_CODE, 3'b010, Sel value that discards top entry
SWAP_CODE, 3'b011, Sel value that exchanges top two entries
CLEAR_CODE, 3'b100, Sel value that empties stack and clears error
DUP_CODE, 3'b101, Sel value that duplicates top (only with optional feature)

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
A  in  WIDTH  operand data to push
Sel  in  SEL_W  opcode, sampled every posedge
Out  out  WIDTH  top of stack (TOS); 0 when empty
Next  out  WIDTH  second entry (NOS); 0 when count<2
count  out  CNT_W  number of valid entries, CNT_W = $clog2(DEPTH+1)
full  out  1  count==DEPTH
empty  out  1  count==0
error  out  1  sticky overflow/underflow/illegal-swap flag

Behaviour:
- One clock; reset is synchronous and active-high.
- reset high at posedge: count=0, every entry=0, Out=0, Next=0, empty=1, full=0, error=0. reset overrides any Sel in the same cycle. Asserting reset mid-sequence discards all contents.
- Outputs are registered or derived only from registered state. A command sampled at edge N is visible on Out, Next, count and flags after edge N; latency is one cycle.
- PUSH: if count<DEPTH, A becomes TOS, old entries shift down one, count+1. If full, the stack is unchanged and error is set (overflow).
- POP: if count>0, TOS is discarded, NOS becomes TOS, count-1, and the vacated slot is zeroed. If empty, the stack is unchanged and error is set (underflow).
- SWAP: if count>=2, TOS and NOS are exchanged and count is unchanged. If count<2, the stack is unchanged and error is set.
- CLEAR: count=0, all entries=0, error=0. CLEAR is legal in any state.
- Any other Sel value, including DUP_CODE when the feature is compiled out: hold all state, error unchanged.
- error is sticky. Only CLEAR or reset deasserts it. A legal command after an error leaves error at 1.
- Entries at index >= count always read as 0, so Out and Next never expose stale data.
- No arithmetic on data; count saturates by construction: it never exceeds DEPTH and never goes below 0.
- Sel decode is full equality on all SEL_W bits; no partial decode.

Optional Feature:
Macro OPERAND_STACK_DUP_EN.
- Defined: Sel==DUP_CODE pushes a copy of TOS, following the PUSH rules. DUP when full sets error with no change. DUP when empty sets error with no change.
- Not defined: DUP_CODE is an unassigned opcode and holds state; no DUP logic is synthesised.

Test Plan:
- Reset then push 0x11, 0x22, 0x33 (DEPTH=4) -> after third edge Out=0x33, Next=0x22, count=3, empty=0, full=0, error=0.
- Push 0x11..0x44 (fills stack), then push 0x55 -> Out=0x44, count=4, full=1, error=1; next Sel=000 keeps error=1.
- From Out=0x44/Next=0x33: SWAP -> Out=0x33, Next=0x44. Then POP x4 -> count=0, Out=0, empty=1. A fifth POP -> error=1.
- CLEAR with error=1 and count=3 -> count=0, Out=0, Next=0, error=0 one cycle later. Also: reset asserted while PUSH is on Sel -> stack stays empty.
- SWAP with count=1 (Out=0x7A) -> Out=0x7A, Next=0, count=1, error=1.
- With OPERAND_STACK_DUP_EN: push 0x5C, DUP -> Out=0x5C, Next=0x5C, count=2. Without the macro: same Sel=101 -> count=1, error=0.
